lsu_ctrl: RTL and testbench

Multi-cycle load/store sequencer between the execute stage and the data-memory bus. It takes one memory operation from execute: width code, effective address, store data and write enable. It runs a valid/ready request and response handshake on the bus, stalling the core until the operation completes. It also generates byte strobes, aligns load data, and flags misaligned accesses and bus timeouts. Execute still performs sign/zero extension on the aligned `rdata` it receives.

---
 rtl/lsu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lsu_ctrl : load/store sequencer between execute and the data-memory bus |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        we,
  input  logic [31:0] wdith,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        bus_rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [15:0] c_to_last = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_valid_q, req_valid_d;
  logic        req_wen_q, req_wen_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic [1:0]  off_q, off_d;

  logic        w_w1, w_w2, w_w4;
  logic        w_legal;
  logic        w_timeout;
  logic [3:0]  w_strb_base;

  assign w_w1 = (wdith == 32'd1);
  assign w_w2 = (wdith == 32'd2);
  assign w_w4 = (wdith == 32'd4);

  // Anything outside {1,2,4}, or not naturally aligned, never reaches the bus.
  assign w_legal = w_w1 | (w_w2 & ~addr[0]) | (w_w4 & (addr[1:0] == 2'b00));

  assign w_strb_base = w_w1 ? 4'b0001 : (w_w2 ? 4'b0011 : 4'b1111);
  assign w_timeout   = (cnt_q == c_to_last);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    req_valid_d = req_valid_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    off_d       = off_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (mem_req) begin
          if (!w_legal) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
            req_wen_d   = we;
            req_addr_d  = {addr[31:2], 2'b00};
            req_wdata_d = wdata << {addr[1:0], 3'b000};
            req_wstrb_d = we ? (w_strb_base << addr[1:0]) : 4'b0000;
            off_d       = addr[1:0];
          end
        end
      end

      S_REQ: begin
        if (bus_req_ready) begin
          state_d     = S_RSP;
          req_valid_d = 1'b0;
          cnt_d       = 16'd0;
        end else if (w_timeout) begin
          state_d     = S_DONE;
          req_valid_d = 1'b0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          cnt_d       = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RSP: begin
        // A response on the last allowed cycle still completes cleanly.
        if (bus_rsp_valid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = bus_rsp_rdata >> {off_q, 3'b000};
          cnt_d   = 16'd0;
        end else if (w_timeout) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        req_valid_d = 1'b0;
        cnt_d       = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
      off_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      req_valid_q <= req_valid_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      off_q       <= off_d;
    end
  end

  assign stall         = mem_req & ~done_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign bus_req_valid = req_valid_q;
  assign bus_req_addr  = req_addr_q;
  assign bus_req_wen   = req_wen_q;
  assign bus_req_wdata = req_wdata_q;
  assign bus_req_wstrb = req_wstrb_q;
  assign bus_rsp_ready = (state_q == S_RSP);

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lsu_ctrl : directed + randomized bench for lsu_ctrl                  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_lsu_ctrl;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, we;
  logic [31:0] wdith, addr, wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_req_valid, bus_req_ready, bus_req_wen;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid, bus_rsp_ready;
  logic [31:0] bus_rsp_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_rdata;

  lsu_ctrl #(.TIMEOUT(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .we            (we),
    .wdith         (wdith),
    .addr          (addr),
    .wdata         (wdata),
    .stall         (stall),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wen   (bus_req_wen),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_ready (bus_rsp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation starting just after a negedge. Edge e counts from the
  // IDLE sample (e=0). The expected timeline is derived up front:
  //   request accepted at edge 1+r, response at edge 2+r+s,
  //   waits of T or more cycles time out after exactly T waiting cycles.
  task automatic run_op(input logic i_we, input logic [31:0] i_w, input logic [31:0] i_a,
                        input logic [31:0] i_d, input logic [31:0] i_rd,
                        input int r, input int s, input bit hold);
    bit          legal, req_to, rsp_to, exp_err;
    int          off, hs, done_e, req_end, base;
    logic [31:0] e_addr, e_wdata, e_strb;

    legal   = (i_w == 1) || (i_w == 2 && (i_a % 2) == 0) || (i_w == 4 && (i_a % 4) == 0);
    off     = int'(i_a % 4);
    e_addr  = i_a - 32'(off);
    e_wdata = i_d << (8 * off);
    base    = (i_w == 1) ? 1 : (i_w == 2) ? 3 : 15;
    e_strb  = i_we ? 32'((base << off) & 15) : 32'd0;
    req_to  = legal && (r >= int'(T));
    hs      = 1 + r;
    rsp_to  = legal && !req_to && (s >= int'(T));
    exp_err = !legal || req_to || rsp_to;
    req_end = req_to ? int'(T) : hs;
    if (!legal)      done_e = 0;
    else if (req_to) done_e = int'(T);
    else if (rsp_to) done_e = hs + int'(T);
    else             done_e = hs + 1 + s;
    if (!exp_err) m_rdata = i_rd >> (8 * off);

    mem_req = 1'b1; we = i_we; wdith = i_w; addr = i_a; wdata = i_d;
    bus_rsp_rdata = i_rd; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;

    for (int e = 0; e <= done_e; e++) begin
      @(posedge clk);
      @(negedge clk);
      check("req_valid", {31'd0, bus_req_valid}, {31'd0, legal && e < req_end});
      check("rsp_ready", {31'd0, bus_rsp_ready},
            {31'd0, legal && !req_to && e >= hs && e < done_e});
      check("done", {31'd0, done}, {31'd0, e == done_e});
      check("stall", {31'd0, stall}, {31'd0, e != done_e});
      if (legal && e < req_end) begin
        check("req_addr", bus_req_addr, e_addr);
        check("req_wen", {31'd0, bus_req_wen}, {31'd0, i_we});
        check("req_wdata", bus_req_wdata, e_wdata);
        check("req_wstrb", {28'd0, bus_req_wstrb}, e_strb);
      end
      if (e == done_e) begin
        check("err", {31'd0, err}, {31'd0, exp_err});
        check("rdata", rdata, m_rdata);
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        mem_req       = hold;
      end else begin
        bus_req_ready = (e >= r);
        bus_rsp_valid = legal && !req_to && (e >= hs + s);
      end
    end

    // DONE must not restart on a still-asserted mem_req.
    @(posedge clk);
    @(negedge clk);
    check("done_clr", {31'd0, done}, 32'd0);
    check("err_clr", {31'd0, err}, 32'd0);
    check("idle_valid", {31'd0, bus_req_valid}, 32'd0);
    mem_req = 1'b0;
  endtask

  initial begin
    int          w_tab[4];
    logic [31:0] ra;
    w_tab = '{1, 2, 4, 3};

    rst_n = 1'b0; mem_req = 1'b0; we = 1'b0; wdith = 32'd0; addr = 32'd0; wdata = 32'd0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0;
    m_rdata = 32'd0;
    repeat (2) @(negedge clk);

    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_valid", {31'd0, bus_req_valid}, 32'd0);
    check("rst_wen", {31'd0, bus_req_wen}, 32'd0);
    check("rst_rsp_ready", {31'd0, bus_rsp_ready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", bus_req_addr, 32'd0);
    check("rst_wdata", bus_req_wdata, 32'd0);
    check("rst_wstrb", {28'd0, bus_req_wstrb}, 32'd0);
    check("rst_stall0", {31'd0, stall}, 32'd0);
    mem_req = 1'b1;
    #1;
    check("rst_stall1", {31'd0, stall}, 32'd1);
    mem_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(1'b0, 32'd4, 32'h8000_0004, 32'h0,         32'hDEAD_BEEF, 0, 0, 1'b0);
    run_op(1'b1, 32'd1, 32'h8000_0003, 32'h0000_00A5, 32'h0BAD_F00D, 0, 0, 1'b0);
    run_op(1'b0, 32'd2, 32'h8000_0002, 32'h0,         32'h1234_5678, 0, 0, 1'b0);
    run_op(1'b0, 32'd4, 32'h8000_0002, 32'h0,         32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(1'b0, 32'd3, 32'h8000_0000, 32'h0,         32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(1'b1, 32'd0, 32'h8000_0000, 32'h1,         32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(1'b1, 32'd2, 32'h8000_0001, 32'h1,         32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op(1'b0, 32'd4, 32'h0000_0100, 32'h0,         32'hCAFE_0001, 3, 0, 1'b0);
    run_op(1'b0, 32'd4, 32'h0000_0200, 32'h0,         32'hCAFE_0002, 4, 0, 1'b0);
    run_op(1'b0, 32'd1, 32'h0000_0301, 32'h0,         32'hCAFE_0003, 1, 3, 1'b1);
    run_op(1'b1, 32'd2, 32'h0000_0402, 32'h0000_BEEF, 32'hCAFE_0004, 0, 4, 1'b1);
    run_op(1'b0, 32'd2, 32'h0000_0506, 32'h0,         32'hA1B2_C3D4, 2, 2, 1'b0);

    // Reset while waiting for a response
    mem_req = 1'b1; we = 1'b0; wdith = 32'd4; addr = 32'h8000_0010;
    bus_rsp_rdata = 32'h5555_AAAA; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    bus_req_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_rsp_ready", {31'd0, bus_rsp_ready}, 32'd1);
    bus_req_ready = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_ready", {31'd0, bus_rsp_ready}, 32'd0);
    check("arst_valid", {31'd0, bus_req_valid}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    m_rdata = 32'd0;
    mem_req = 1'b0;
    bus_rsp_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      check("stale_done", {31'd0, done}, 32'd0);
      check("stale_rsp_ready", {31'd0, bus_rsp_ready}, 32'd0);
      check("stale_rdata", rdata, 32'd0);
    end
    bus_rsp_valid = 1'b0;
    run_op(1'b0, 32'd4, 32'h8000_0020, 32'h0, 32'h0F1E_2D3C, 0, 1, 1'b0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      run_op(1'($urandom_range(0, 1)), 32'(w_tab[$urandom_range(0, 3)]), ra, $urandom,
             $urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
